// File: rtl/lms_fir_error.sv
// FIR filter / error stage for an LMS adaptive filter. It keeps the input delay line, runs one
// multiply-accumulate per tap and hands {delay line, y, error} downstream over a valid/ready handshake.
module lms_fir_error #(
    parameter int WIDTH       = 16,
    parameter int FRAC        = 12,
    parameter int COEFF_WIDTH = 16,
    parameter int COEFF_FRAC  = 14,
    parameter int TAPS        = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic signed [WIDTH-1:0]       i_sample,
    input  logic signed [WIDTH-1:0]       i_desired,
    input  logic [TAPS*COEFF_WIDTH-1:0]   i_weights,
    output logic [TAPS*WIDTH-1:0]         o_din,
    output logic signed [WIDTH-1:0]       o_y,
    output logic signed [WIDTH-1:0]       o_error,
    output logic                          o_ovr,
    output logic                          o_valid,
    input  logic                          i_ready
);
    localparam int IDX_W   = $clog2(TAPS);
    localparam int PROD_W  = WIDTH + COEFF_WIDTH;
    localparam int ACC_W   = PROD_W + $clog2(TAPS);
    localparam int Y_SHIFT = (FRAC + COEFF_FRAC) - FRAC;

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                        state_reg, state_next;
    logic signed [WIDTH-1:0]       din_reg [TAPS];
    logic signed [COEFF_WIDTH-1:0] w_reg   [TAPS];
    logic signed [WIDTH-1:0]       desired_reg;
    logic signed [ACC_W-1:0]       acc_reg;
    logic [IDX_W-1:0]              idx_reg;
    logic                          ready_reg, valid_reg, ovr_reg;
    logic signed [WIDTH-1:0]       y_reg, error_reg;

    logic                          accept;
    logic signed [PROD_W-1:0]      prod;
    logic signed [ACC_W-1:0]       y_full;
    logic                          y_ovf, err_ovf;
    logic signed [WIDTH-1:0]       y_sat, err_sat;
    logic [WIDTH:0]                err_full;

    assign accept = (state_reg == IDLE) && i_valid && ready_reg;

    // Delay line and weight snapshot both update only on an accepted sample.
    generate
        for (genvar gi = 0; gi < TAPS; gi++) begin : g_tap
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    din_reg[gi] <= '0;
                    w_reg[gi]   <= '0;
                end else if (accept) begin
                    if (gi == 0) begin
                        din_reg[gi] <= i_sample;
                    end else begin
                        din_reg[gi] <= din_reg[(gi == 0) ? 0 : gi-1];
                    end
                    w_reg[gi] <= i_weights[gi*COEFF_WIDTH +: COEFF_WIDTH];
                end
            end
            assign o_din[gi*WIDTH +: WIDTH] = din_reg[gi];
        end
    endgenerate

    assign prod = din_reg[idx_reg] * w_reg[idx_reg];

    // Rescale to the sample format, then clamp y and error independently.
    always_comb begin
        y_full   = acc_reg >>> Y_SHIFT;
        y_ovf    = (y_full[ACC_W-1:WIDTH-1] != {(ACC_W-WIDTH+1){y_full[WIDTH-1]}});
        y_sat    = y_ovf ? {y_full[ACC_W-1], {(WIDTH-1){~y_full[ACC_W-1]}}} : y_full[WIDTH-1:0];
        err_full = {desired_reg[WIDTH-1], desired_reg} - {y_sat[WIDTH-1], y_sat};
        err_ovf  = (err_full[WIDTH] != err_full[WIDTH-1]);
        err_sat  = err_ovf ? {err_full[WIDTH], {(WIDTH-1){~err_full[WIDTH]}}} : err_full[WIDTH-1:0];
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = MAC;
            MAC:     if (idx_reg == IDX_W'(TAPS-1)) state_next = OUT;
            OUT:     if (valid_reg && i_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= IDLE;
            ready_reg   <= 1'b0;
            valid_reg   <= 1'b0;
            ovr_reg     <= 1'b0;
            y_reg       <= '0;
            error_reg   <= '0;
            acc_reg     <= '0;
            idx_reg     <= '0;
            desired_reg <= '0;
        end else begin
            state_reg <= state_next;
            ready_reg <= (state_next == IDLE);
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        desired_reg <= i_desired;
                        acc_reg     <= '0;
                        idx_reg     <= '0;
                    end
                end
                MAC: begin
                    acc_reg <= acc_reg + ACC_W'(prod);
                    idx_reg <= (idx_reg == IDX_W'(TAPS-1)) ? '0 : idx_reg + 1'b1;
                end
                OUT: begin
                    // First OUT cycle registers the result; later cycles hold it until taken.
                    if (!valid_reg) begin
                        y_reg     <= y_sat;
                        error_reg <= err_sat;
                        ovr_reg   <= y_ovf | err_ovf;
                        valid_reg <= 1'b1;
                    end else if (i_ready) begin
                        valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_ready = ready_reg;
    assign o_valid = valid_reg;
    assign o_y     = y_reg;
    assign o_error = error_reg;
    assign o_ovr   = ovr_reg;
endmodule
